seg_scan_ctrl: RTL and testbench

- Controller for the 4-digit seven-segment scan display.
- Accepts 16-bit display updates from the CPU MMIO side over a valid/ready handshake and commits them only at frame boundaries, so the display never shows a torn value.
- Sequences digit scanning with a per-slot blanking window to prevent ghosting, and applies 3-bit PWM brightness.
- Drives the digit enables and the 4-bit digit value into the existing hex-to-segment decoder.

---
 rtl/seg_scan_ctrl_if.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
//
// Purpose:
//   Write-side bus of the seven-segment scan controller. The CPU MMIO block
//   pushes 16-bit display updates over a valid/ready handshake.
//
// Signals:
//   wr_valid  requester -> controller  update request (held until accepted)
//   wr_ready  controller -> requester  controller can take an update
//   wr_data   requester -> controller  new value, digit i = wr_data[4i+3:4i]
//   wr_mask   requester -> controller  per-digit write enable
//
// Modports:
//   master : CPU / MMIO side (drives valid, data, mask)
//   slave  : seg_scan_ctrl (drives ready)
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_mask,
    output wr_ready
  );

endinterface : seg_scan_ctrl_if

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Purpose:
//   Scan controller for a 4-digit seven-segment display.
//   - Accepts 16-bit display updates over a valid/ready handshake and holds
//     them in a pending register until the next frame boundary, so a frame
//     is never drawn with a mix of old and new digits.
//   - Scans one digit per slot of CLK_DIV cycles; the first BLANK_CYC cycles
//     of every slot keep all enables off so the previous digit's segments
//     can discharge (anti-ghosting).
//   - Applies 3-bit PWM brightness: a lit slot is gated by pwm <= bright,
//     giving (bright+1)/8 duty.
//   - Feeds the digit enables and the selected 4-bit digit value to the
//     external hex-to-segment decoder.
//
// Parameters:
//   CLK_DIV    clk cycles per digit slot, 2 .. 2^20
//   BLANK_CYC  blanking cycles at the start of each slot, < CLK_DIV
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset
//   wr          slave modport of seg_scan_ctrl_if (valid/ready/data/mask)
//   bright      in   [2:0] brightness, 0 = 1/8 duty, 7 = full
//   lz_en       in   leading-zero suppression enable (SEG_LZ_SUPPRESS_EN only)
//   ena         out  [3:0] one-hot digit enable, bit0 = rightmost digit
//   num         out  [3:0] digit value for the segment decoder
//   disp_val    out  [15:0] currently committed display value
//   frame_done  out  one-cycle pulse after the last cycle of slot 3
//
// Build option:
//   SEG_LZ_SUPPRESS_EN  when defined, adds lz_en. With lz_en=1, digit i
//                       (i=3..1) stays dark while digits 3..i of disp_val are
//                       all zero. Digit 0 is always shown.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave wr,
  input  logic [2:0]     bright,
`ifdef SEG_LZ_SUPPRESS_EN
  input  logic           lz_en,
`endif
  output logic [3:0]     ena,
  output logic [3:0]     num,
  output logic [15:0]    disp_val,
  output logic           frame_done
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned    CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  // Position inside a digit slot.
  typedef enum logic {
    SLOT_BLANK = 1'b0,   // anti-ghosting window, all enables off
    SLOT_ON    = 1'b1    // digit may be lit, subject to PWM
  } slot_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,        cnt_d;        // cycle within slot
  logic [1:0]       scan_q,       scan_d;       // active digit slot
  logic [2:0]       pwm_q,        pwm_d;        // free-running PWM phase
  logic             pend_flag_q,  pend_flag_d;  // an accepted update waits
  logic [15:0]      pend_val_q,   pend_val_d;   // merged value to commit
  logic [15:0]      disp_val_q,   disp_val_d;   // committed display value
  logic [3:0]       ena_q,        ena_d;
  logic [3:0]       num_q,        num_d;
  logic             frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------
  // Decode of the current scan position
  // ---------------------------------------------------------------------------
  slot_state_e slot_state;
  logic        cnt_wrap;     // last cycle of the current slot
  logic        frame_end;    // last cycle of slot 3: the commit point
  logic        pwm_on;       // PWM phase inside the lit part of the period
  logic        digit_sup;    // current digit suppressed as a leading zero
  logic        wr_xfer;      // handshake completes on this edge
  logic [15:0] wr_merged;    // committed value with masked digits replaced

  assign cnt_wrap   = (cnt_q == CNT_LAST);
  assign frame_end  = cnt_wrap && (scan_q == 2'd3);
  assign slot_state = (cnt_q < BLANK_END) ? SLOT_BLANK : SLOT_ON;
  assign pwm_on     = (pwm_q <= bright);

  // Ready only depends on the pending flag: a single pending slot means a
  // second update can never overwrite one that has not yet been shown.
  assign wr.wr_ready = ~pend_flag_q;
  assign wr_xfer     = wr.wr_valid & ~pend_flag_q;

`ifdef SEG_LZ_SUPPRESS_EN
  // lead_zero[i] = digits 3..i of the committed value are all zero.
  // Bit 0 stays 0 so the rightmost digit is never suppressed.
  logic [3:0] lead_zero;

  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_val_q[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (disp_val_q[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (disp_val_q[7:4]  == 4'h0);
  end

  assign digit_sup = lz_en & lead_zero[scan_q];
`else
  assign digit_sup = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write merge: a 0 mask bit keeps the committed digit. The merge is taken
  // against disp_val at transfer time; disp_val cannot change between the
  // transfer and the commit because only the pending value ever commits.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_merged = disp_val_q;
    for (int i = 0; i < 4; i++) begin
      if (wr.wr_mask[i]) begin
        wr_merged[4*i +: 4] = wr.wr_data[4*i +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot / scan / PWM counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    cnt_d  = cnt_q + 1'b1;
    scan_d = scan_q;
    pwm_d  = pwm_q + 3'd1;

    if (cnt_wrap) begin
      cnt_d  = '0;
      scan_d = scan_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending update and frame-boundary commit
  //
  // A transfer only happens with the pending flag clear, and a commit only
  // happens with it set, so the two never act on the same edge. A transfer
  // landing on the boundary cycle therefore waits a whole frame to commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_flag_d = pend_flag_q;
    pend_val_d  = pend_val_q;
    disp_val_d  = disp_val_q;

    if (frame_end && pend_flag_q) begin
      disp_val_d  = pend_val_q;
      pend_flag_d = 1'b0;
    end

    if (wr_xfer) begin
      pend_val_d  = wr_merged;
      pend_flag_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display outputs, registered one cycle behind the scan position
  // ---------------------------------------------------------------------------
  always_comb begin
    ena_d        = 4'b0000;
    num_d        = disp_val_q[{scan_q, 2'b00} +: 4];
    frame_done_d = frame_end;

    if ((slot_state == SLOT_ON) && pwm_on && !digit_sup) begin
      ena_d = 4'b0001 << scan_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  // NOTE: the pending value register is reset along with the flag; it is a
  // single 16-bit word, and clearing it keeps its contents defined after a
  // reset that discards an in-flight update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      scan_q       <= 2'd0;
      pwm_q        <= 3'd0;
      pend_flag_q  <= 1'b0;
      pend_val_q   <= 16'h0000;
      disp_val_q   <= 16'h0000;
      ena_q        <= 4'b0000;
      num_q        <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      pwm_q        <= pwm_d;
      pend_flag_q  <= pend_flag_d;
      pend_val_q   <= pend_val_d;
      disp_val_q   <= disp_val_d;
      ena_q        <= ena_d;
      num_q        <= num_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ena        = ena_q;
  assign num        = num_q;
  assign disp_val   = disp_val_q;
  assign frame_done = frame_done_q;

  // At most one digit may ever be driven.
  a_ena_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(ena_q));

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Randomised bench for seg_scan_ctrl with CLK_DIV=16, BLANK_CYC=4. The
// reference model works from the absolute cycle index since reset release:
// slot position, digit and PWM phase are plain divisions/modulos of it, and
// the display value / pending update are tracked as two words and a flag.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int CLK_DIV   = 16;
  localparam int BLANK_CYC = 4;
  localparam int FRAME     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  bright;
`ifdef SEG_LZ_SUPPRESS_EN
  logic        lz_en;
`endif
  logic [3:0]  ena;
  logic [3:0]  num;
  logic [15:0] disp_val;
  logic        frame_done;

  seg_scan_ctrl_if wr_if ();

  seg_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if.slave),
    .bright     (bright),
`ifdef SEG_LZ_SUPPRESS_EN
    .lz_en      (lz_en),
`endif
    .ena        (ena),
    .num        (num),
    .disp_val   (disp_val),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_t;          // cycle index since reset release
  logic [15:0] m_disp;       // committed value
  logic [15:0] m_pend_val;   // accepted, not yet committed
  bit          m_pend;
  bit          last_xfer;    // the most recent step performed a transfer

  task automatic model_reset();
    m_t        = 0;
    m_disp     = 16'h0000;
    m_pend_val = 16'h0000;
    m_pend     = 1'b0;
    last_xfer  = 1'b0;
  endtask

  // Advance one clock with the inputs currently driven, then compare every
  // output against what the model predicts for the cycle just clocked.
  task automatic step();
    int          c, cnt, slot, pw;
    bit          boundary, xfer, sup;
    logic [15:0] merged;
    logic [3:0]  e_ena, e_num;

    c    = m_t;
    cnt  = c % CLK_DIV;
    slot = (c / CLK_DIV) % 4;
    pw   = c % 8;

    sup = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
    sup = lz_en && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0000);
`endif
    e_ena = (cnt >= BLANK_CYC && pw <= int'(bright) && !sup) ? 4'(1 << slot) : 4'h0;
    e_num = 4'((m_disp >> (4 * slot)) & 16'h000F);

    boundary = (c % FRAME) == FRAME - 1;
    xfer     = wr_if.wr_valid && !m_pend;

    merged = m_disp;
    for (int i = 0; i < 4; i++) begin
      if (wr_if.wr_mask[i]) merged[4*i +: 4] = wr_if.wr_data[4*i +: 4];
    end

    if (boundary && m_pend) begin
      m_disp = m_pend_val;
      m_pend = 1'b0;
    end
    if (xfer) begin
      m_pend_val = merged;
      m_pend     = 1'b1;
    end
    last_xfer = xfer;
    m_t++;

    @(posedge clk);
    @(negedge clk);
    check($sformatf("ena@c%0d", c),        ena,            e_ena);
    check($sformatf("num@c%0d", c),        num,            e_num);
    check($sformatf("frame_done@c%0d", c), frame_done,     boundary);
    check($sformatf("disp_val@c%0d", c),   disp_val,       m_disp);
    check($sformatf("wr_ready@c%0d", c),   wr_if.wr_ready, !m_pend);
  endtask

  task automatic idle(input int n);
    wr_if.wr_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Idle until the next step will clock the cycle with the given frame phase.
  task automatic idle_to(input int phase);
    wr_if.wr_valid = 1'b0;
    for (int k = 0; k < FRAME && (m_t % FRAME) != phase; k++) step();
  endtask

  // Hold a request until it is accepted (bounded), then drop valid.
  task automatic write(input logic [15:0] data, input logic [3:0] mask);
    wr_if.wr_data  = data;
    wr_if.wr_mask  = mask;
    wr_if.wr_valid = 1'b1;
    last_xfer      = 1'b0;
    for (int k = 0; k < 4 * FRAME && !last_xfer; k++) step();
    if (!last_xfer) check("wr_accept_timeout", {31'd0, last_xfer}, 32'd1);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string when);
    check({when, "_ena"},        ena,            4'h0);
    check({when, "_num"},        num,            4'h0);
    check({when, "_disp_val"},   disp_val,       16'h0000);
    check({when, "_frame_done"}, frame_done,     1'b0);
    check({when, "_wr_ready"},   wr_if.wr_ready, 1'b1);
  endtask

  // Count cycles with any digit lit over one full frame; the expected count
  // is (lit cycles per slot) * 4, derived from blanking and PWM duty only.
  task automatic duty_frame(input logic [2:0] b);
    int lit, exp_lit;
    bright = b;
    idle_to(0);
    lit = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (ena != 4'h0) lit++;
    end
    exp_lit = 0;
    for (int c = BLANK_CYC; c < CLK_DIV; c++) if ((c % 8) <= int'(b)) exp_lit++;
    check($sformatf("duty_bright%0d", b), lit, 4 * exp_lit);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bright         = 3'd7;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 16'h0000;
    wr_if.wr_mask  = 4'h0;
`ifdef SEG_LZ_SUPPRESS_EN
    lz_en          = 1'b0;
`endif

    // Reset, checked while held.
    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Free-running scan with no writes, full brightness.
    idle(2 * FRAME);

    // First update mid slot 1; shown only after the frame boundary.
    idle_to(CLK_DIV + 6);
    write(16'h1234, 4'hF);
    check("no_early_commit", disp_val, 16'h0000);
    check("ready_low_after_xfer", wr_if.wr_ready, 1'b0);
    idle(2 * FRAME);
    check("commit_1234", disp_val, 16'h1234);

    // Masked merge.
    write(16'hABCD, 4'b0101);
    idle(2 * FRAME);
    check("merge_result", disp_val, 16'h1B3D);

    // Transfer on the exact boundary cycle commits one frame later.
    idle_to(FRAME - 1);
    wr_if.wr_data  = 16'h5A5A;
    wr_if.wr_mask  = 4'hF;
    wr_if.wr_valid = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    check("fd_on_boundary", frame_done, 1'b1);
    check("no_commit_on_boundary", disp_val, 16'h1B3D);
    check("ready_after_boundary_xfer", wr_if.wr_ready, 1'b0);
    idle(FRAME - 1);
    check("still_pending", disp_val, 16'h1B3D);
    step();
    check("late_commit", disp_val, 16'h5A5A);
    idle(4);

    // Empty mask still transfers and commits an unchanged value.
    write(16'hFFFF, 4'h0);
    idle(2 * FRAME);
    check("mask0_unchanged", disp_val, 16'h5A5A);

    // PWM duty.
    duty_frame(3'd0);
    duty_frame(3'd3);
    duty_frame(3'd7);

    // Random writes and brightness changes.
    for (int k = 0; k < 8 * FRAME; k++) begin
      if (k % 32 == 0) bright = 3'($urandom_range(0, 7));
`ifdef SEG_LZ_SUPPRESS_EN
      if (k % 64 == 17) lz_en = 1'($urandom_range(0, 1));
`endif
      if (!wr_if.wr_valid && $urandom_range(0, 15) == 0) begin
        wr_if.wr_data  = 16'($urandom);
        wr_if.wr_mask  = 4'($urandom);
        wr_if.wr_valid = 1'b1;
      end
      step();
      if (last_xfer) wr_if.wr_valid = 1'b0;
    end
    idle(2 * FRAME);

    // Make the committed value nonzero, then reset mid-frame with a write pending.
    bright = 3'd7;
    write(16'hC0DE, 4'hF);
    idle(2 * FRAME);
    write(16'h7777, 4'hF);
    idle(5);
    rst = 1'b0;
    #1 check_reset_outputs("midframe_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b1;
    wr_if.wr_valid = 1'b0;
    model_reset();
    idle(2 * FRAME);
    check("no_commit_after_rst", disp_val, 16'h0000);

`ifdef SEG_LZ_SUPPRESS_EN
    // Leading-zero suppression: 0x0005 lights only the rightmost digit.
    begin
      logic [3:0] seen;
      lz_en = 1'b1;
      write(16'h0005, 4'hF);
      idle(2 * FRAME);
      seen = 4'h0;
      for (int k = 0; k < 2 * FRAME; k++) begin
        step();
        seen |= ena;
      end
      check("lz_only_digit0", seen, 4'b0001);
      write(16'h0040, 4'hF);
      idle(2 * FRAME);
      seen = 4'h0;
      for (int k = 0; k < FRAME; k++) begin
        step();
        seen |= ena;
      end
      check("lz_digits_1_0", seen, 4'b0011);
      lz_en = 1'b0;
      idle(FRAME);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_seg_scan_ctrl
